// File: rtl/seg_mux_decoder.sv
// Decodes a multiplexed active-low 6-digit 7-segment bus back into a 24-bit hex number.
// Inputs are synchronized, debounced by dwell count, and assembled into complete frames.
module seg_mux_decoder #(
    parameter int STABLE  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_leds,
    input  logic [5:0]  seg_nCS,
    output logic [23:0] number,
    output logic        number_valid,
    output logic        frame_done,
    output logic        code_err,
    output logic        sel_err
);
    localparam logic [4:0]  STAB_LD = 5'(STABLE);
    localparam logic [15:0] TO_LD   = 16'(TIMEOUT);

    logic [7:0]       r_leds_m, r_leds_s;
    logic [5:0]       r_cs_m, r_cs_s;
    logic [4:0]       r_stab;
    logic [15:0]      r_to_cnt;
    logic [5:0][3:0]  r_shadow;
    logic [5:0]       r_mask;
    logic [23:0]      r_number;
    logic             r_valid, r_frame_done, r_code_err, r_sel_err;

    logic             w_change, w_eval, w_blank, w_sel_ok, w_code_ok;
    logic             w_accept, w_full, w_timeout;
    logic [2:0]       w_dig;
    logic [3:0]       w_nib;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds_m <= '1;
            r_leds_s <= '1;
            r_cs_m   <= '1;
            r_cs_s   <= '1;
        end else begin
            r_leds_m <= seg_leds;
            r_leds_s <= r_leds_m;
            r_cs_m   <= seg_nCS;
            r_cs_s   <= r_cs_m;
        end
    end

    // r_stab counts how long the value about to land in the _s stage has been held.
    assign w_change = {r_cs_m, r_leds_m} != {r_cs_s, r_leds_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stab <= '0;
        else if (w_change)
            r_stab <= 5'd1;
        else if (r_stab != 5'd31)
            r_stab <= r_stab + 5'd1;
    end

    assign w_eval = (r_stab == STAB_LD);

    always_comb begin
        w_dig    = 3'd0;
        w_sel_ok = 1'b1;
        w_blank  = 1'b0;
        case (r_cs_s)
            6'b011111: w_dig = 3'd0;
            6'b101111: w_dig = 3'd1;
            6'b110111: w_dig = 3'd2;
            6'b111011: w_dig = 3'd3;
            6'b111101: w_dig = 3'd4;
            6'b111110: w_dig = 3'd5;
            6'b111111: begin w_blank = 1'b1; w_sel_ok = 1'b0; end
            default:   w_sel_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_nib     = 4'h0;
        w_code_ok = 1'b1;
        case (r_leds_s[6:0])
            7'h40: w_nib = 4'h0;
            7'h79: w_nib = 4'h1;
            7'h24: w_nib = 4'h2;
            7'h30: w_nib = 4'h3;
            7'h19: w_nib = 4'h4;
            7'h12: w_nib = 4'h5;
            7'h02: w_nib = 4'h6;
            7'h78: w_nib = 4'h7;
            7'h00: w_nib = 4'h8;
            7'h10: w_nib = 4'h9;
            7'h08: w_nib = 4'hA;
            7'h03: w_nib = 4'hB;
            7'h46: w_nib = 4'hC;
            7'h21: w_nib = 4'hD;
            7'h06: w_nib = 4'hE;
            7'h0E: w_nib = 4'hF;
            default: w_code_ok = 1'b0;
        endcase
    end

    assign w_accept  = w_eval && w_sel_ok && w_code_ok;
    assign w_full    = &r_mask;
    assign w_timeout = (r_to_cnt == 16'd1) && !w_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_to_cnt <= '0;
        else if (w_accept)
            r_to_cnt <= TO_LD;
        else if (r_to_cnt != 16'd0)
            r_to_cnt <= r_to_cnt - 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow     <= '0;
            r_mask       <= '0;
            r_number     <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
            r_code_err   <= 1'b0;
            r_sel_err    <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            r_code_err   <= 1'b0;
            r_sel_err    <= 1'b0;
            if (w_full) begin
                r_mask       <= '0;
                r_number     <= r_shadow;
                r_frame_done <= 1'b1;
                r_valid      <= 1'b1;
            end else if (w_timeout) begin
                r_valid <= 1'b0;
            end
            // A digit landing on the completion cycle starts the next frame.
            if (w_eval && !w_blank) begin
                if (w_sel_ok && w_code_ok) begin
                    r_shadow[w_dig] <= w_nib;
                    r_mask[w_dig]   <= 1'b1;
                end else if (w_sel_ok) begin
                    r_code_err <= 1'b1;
                    r_mask     <= '0;
                end else begin
                    r_sel_err <= 1'b1;
                    r_mask    <= '0;
                end
            end
        end
    end

    assign number       = r_number;
    assign number_valid = r_valid;
    assign frame_done   = r_frame_done;
    assign code_err     = r_code_err;
    assign sel_err      = r_sel_err;

endmodule

// File: tb/tb_seg_mux_decoder.sv
// Directed bench for seg_mux_decoder: frame assembly, error pulses, debounce, timeout, reset.
module tb_seg_mux_decoder;
    localparam int STABLE  = 2;
    localparam int TIMEOUT = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_leds;
    logic [5:0]  seg_nCS;
    logic [23:0] number;
    logic        number_valid, frame_done, code_err, sel_err;

    int n_chk = 0, n_pass = 0;
    int n_fd = 0, n_ce = 0, n_se = 0;
    int s_fd, s_ce, s_se;

    seg_mux_decoder #(.STABLE(STABLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .seg_leds(seg_leds), .seg_nCS(seg_nCS),
        .number(number), .number_valid(number_valid), .frame_done(frame_done),
        .code_err(code_err), .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) n_fd++;
        if (code_err)   n_ce++;
        if (sel_err)    n_se++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    function automatic logic [5:0] cs_of(input int k);
        logic [5:0] one = 6'b100000;
        return ~(one >> k);
    endfunction

    task automatic present(input logic [5:0] cs, input logic [7:0] leds, input int n);
        seg_nCS  = cs;
        seg_leds = leds;
        repeat (n) @(negedge clk);
    endtask

    task automatic snap();
        s_fd = n_fd; s_ce = n_ce; s_se = n_se;
    endtask

    logic [7:0] codes_a[6] = '{8'h79, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
    logic [7:0] codes_b[5] = '{8'h78, 8'h80, 8'h90, 8'h88, 8'h83};

    initial begin
        bit got;
        rst_n = 1'b0; seg_leds = 8'hFF; seg_nCS = 6'h3F;
        repeat (3) @(negedge clk);
        chk("rst_number", 32'(number), 32'h0);
        chk("rst_valid", 32'(number_valid), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_ce", 32'(code_err), 32'h0);
        chk("rst_se", 32'(sel_err), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full frame 1..6 on digits 0..5
        snap();
        for (int k = 0; k < 6; k++) present(cs_of(k), codes_a[k], 8);
        present(6'h3F, 8'hFF, 8);
        chk("t1_number", 32'(number), 32'h654321);
        chk("t1_fd_once", 32'(n_fd - s_fd), 32'd1);
        chk("t1_valid", 32'(number_valid), 32'd1);

        // Bad code mid-frame clears the mask
        snap();
        for (int k = 0; k < 3; k++) present(cs_of(k), codes_a[k], 8);
        present(6'b110111, 8'hFF, 8);
        for (int k = 3; k < 6; k++) present(cs_of(k), codes_a[k], 8);
        present(6'h3F, 8'hFF, 8);
        chk("t2_ce_once", 32'(n_ce - s_ce), 32'd1);
        chk("t2_no_fd", 32'(n_fd - s_fd), 32'd0);
        chk("t2_number", 32'(number), 32'h654321);
        chk("t2_valid", 32'(number_valid), 32'd1);

        // Bad select, then blanking
        snap();
        present(6'b001111, 8'h80, 8);
        present(6'h3F, 8'hFF, 8);
        chk("t3_se_once", 32'(n_se - s_se), 32'd1);
        chk("t3_no_ce", 32'(n_ce - s_ce), 32'd0);
        snap();
        present(6'h3F, 8'hFF, 8);
        chk("t3_blank_no_se", 32'(n_se - s_se), 32'd0);

        // Partial frame, then a toggling bus that must never be accepted
        for (int k = 0; k < 5; k++) present(cs_of(k), codes_b[k], 8);
        present(6'h3F, 8'hFF, 8);
        snap();
        for (int i = 0; i < 20; i++) present((i % 2) ? 6'b001111 : 6'b111110, 8'hC6, 1);
        present(6'h3F, 8'hFF, 8);
        chk("t4_no_fd", 32'(n_fd - s_fd), 32'd0);
        chk("t4_no_se", 32'(n_se - s_se), 32'd0);
        chk("t4_no_ce", 32'(n_ce - s_ce), 32'd0);

        // Completing digit 5 finishes the frame; then let it time out
        seg_nCS = cs_of(5); seg_leds = 8'hC6;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (frame_done) got = 1'b1;
        end
        chk("t5_fd_seen", 32'(got), 32'd1);
        seg_nCS = 6'h3F; seg_leds = 8'hFF;
        chk("t5_number", 32'(number), 32'hCBA987);
        repeat (TIMEOUT - 2) @(negedge clk);
        chk("t5_valid_before_to", 32'(number_valid), 32'd1);
        @(negedge clk);
        chk("t5_valid_after_to", 32'(number_valid), 32'd0);
        chk("t5_number_kept", 32'(number), 32'hCBA987);

        // Reset mid-frame discards the partial frame
        for (int k = 0; k < 3; k++) present(cs_of(k), codes_a[k], 8);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_rst_number", 32'(number), 32'h0);
        chk("t6_rst_valid", 32'(number_valid), 32'd0);
        chk("t6_rst_fd", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        present(6'h3F, 8'hFF, 4);
        snap();
        for (int k = 3; k < 6; k++) present(cs_of(k), codes_a[k], 8);
        present(6'h3F, 8'hFF, 8);
        chk("t6_no_fd", 32'(n_fd - s_fd), 32'd0);
        chk("t6_valid", 32'(number_valid), 32'd0);
        chk("t6_number", 32'(number), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg_mux_decoder.md
SEG_MUX_DECODER -- requirements
Module: seg_mux_decoder

Interface
REQ-001 SHALL have parameter STABLE, 2: consecutive identical synchronized samples required before a digit is accepted (range 1..15).
REQ-002 SHALL have parameter TIMEOUT, 1024: clk cycles without an accepted digit before number_valid drops (range 2..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port seg_leds  input  8  segment bus {dp,g,f,e,d,c,b,a}, active-low.
REQ-006 SHALL have port seg_nCS  input  6  digit selects, active-low.
REQ-007 SHALL have port number  output  24  last complete decoded frame; digit k in bits [4k+3:4k].
REQ-008 SHALL have port number_valid  output  1  high while number holds a frame and no timeout has occurred.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse when number updates.
REQ-010 SHALL have port code_err  output  1  one-cycle pulse when a selected digit carries an undecodable segment pattern.
REQ-011 SHALL have port sel_err  output  1  one-cycle pulse when seg_nCS is neither all-ones nor a single zero.

Function
REQ-012 SHALL pass seg_leds and seg_nCS through a 2-flop synchronizer before any use.
REQ-013 SHALL count consecutive cycles with unchanged synchronized {seg_nCS,seg_leds}; the count restarts at 1 on any change and saturates.
REQ-014 SHALL evaluate a sample exactly once per dwell, on the cycle the count reaches STABLE.
REQ-015 SHALL map seg_nCS 011111/101111/110111/111011/111101/111110 to digits 0/1/2/3/4/5 respectively.
REQ-016 SHALL ignore dp (bit 7) and decode bits [6:0]: 40=0, 79=1, 24=2, 30=3, 19=4, 12=5, 02=6, 78=7, 00=8, 10=9, 08=A, 03=b, 46=C, 21=d, 06=E, 0E=F (hex).
REQ-017 SHALL treat seg_nCS = 111111 as blanking: no accept, no error, frame state unchanged.
REQ-018 SHALL, on an evaluated sample with valid select and valid code, write the nibble into the shadow register at that digit and set that digit's seen-mask bit; a repeated digit overwrites the nibble, mask unchanged.
REQ-019 SHALL, on an evaluated sample with valid select and invalid code, pulse code_err, clear the seen mask, and leave number unchanged.
REQ-020 SHALL, on an evaluated sample with invalid select, pulse sel_err and clear the seen mask.
REQ-021 SHALL, on the cycle after the seen mask becomes 111111, load number from the shadow register, pulse frame_done, set number_valid, and clear the seen mask.
REQ-022 SHALL reload the timeout counter on every accepted digit, and clear number_valid (number retained) when TIMEOUT cycles elapse without one.
REQ-023 SHALL give frame_done priority over timeout when both occur in the same cycle (number_valid stays 1).
REQ-024 SHALL produce pin-to-accept latency of 2 + STABLE cycles after the last input change; accept-to-number latency 1 cycle.

Reset
REQ-025 SHALL, while rst_n is low, hold number = 0, number_valid = 0, frame_done = 0, code_err = 0, sel_err = 0, with synchronizers = all-ones, shadow = 0, seen mask = 0, stable and timeout counters = 0.
REQ-026 SHALL discard any partial frame on reset assertion mid-frame; after release, a full new 6-digit frame is required before number_valid rises.

Verification
REQ-027 SHALL show: digits 0..5 presented with codes for 1,2,3,4,5,6, each held 8 cycles -> number = 0x654321, single frame_done pulse, number_valid = 1.
REQ-028 SHALL show: select 110111 with seg_leds = FF -> code_err pulses once per dwell, mask cleared, number unchanged.
REQ-029 SHALL show: seg_nCS = 001111 held 8 cycles -> sel_err pulses once; blanking 111111 -> no pulse.
REQ-030 SHALL show: with STABLE = 2, input toggling every clk cycle -> no digit accepted, no error pulse.
REQ-031 SHALL show: after a valid frame, inputs frozen at 111111 for TIMEOUT cycles -> number_valid falls on cycle TIMEOUT, number retained.
REQ-032 SHALL show: rst_n pulsed low after 3 digits -> outputs at reset values; next 3 digits alone do not raise frame_done.
